// File: rtl/restador_serie.sv
// ---------------------------------------------------------------------------
// restador_serie -- bit-serial unsigned subtractor (a - b), LSB first.
//
// Takes two WIDTH-bit unsigned operands on a start pulse and resolves one
// bit per clock through a single ripple-borrow flop. The (WIDTH+1)-bit
// two's-complement difference appears on diff together with a one-cycle
// done pulse. diff[WIDTH] is the final borrow, so it is 1 exactly when a < b.
//
// Ports:
//   clk    in   1        system clock, rising edge
//   rst    in   1        synchronous active-high reset, dominates all inputs
//   start  in   1        request; accepted only while busy=0
//   a      in   WIDTH    minuend, captured on the accepting edge
//   b      in   WIDTH    subtrahend, captured on the accepting edge
//   diff   out  WIDTH+1  a-b, updated only when a subtraction completes
//   busy   out  1        high while bits are being processed
//   done   out  1        one-cycle pulse marking a new diff
//   zero   out  1        (RESTADOR_ZERO_FLAG_EN only) 1 iff a == b, held
//                        alongside diff
//
// Optional feature macro: RESTADOR_ZERO_FLAG_EN
// ---------------------------------------------------------------------------
module restador_serie #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH:0]   diff,
    output logic             busy,
    output logic             done
`ifdef RESTADOR_ZERO_FLAG_EN
    ,
    output logic             zero
`endif
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sa;       // minuend bits, later reused to hold result bits
    logic [WIDTH-1:0] sb;       // subtrahend bits
    logic [CW-1:0]    cnt;
    logic             borrow;

    logic             d_bit;
    logic             borrow_nxt;
    logic [WIDTH:0]   diff_nxt;

    // One full-subtractor cell working on the current LSBs.
    assign d_bit      = sa[0] ^ sb[0] ^ borrow;
    assign borrow_nxt = (~sa[0] & sb[0]) | (~(sa[0] ^ sb[0]) & borrow);

    // As sa shifts right, each result bit enters at its MSB, so after the
    // last shift the result bits sit in order. On the final edge the
    // freshest bit and borrow have not been registered yet, so they are
    // spliced in directly.
    assign diff_nxt = {borrow_nxt, d_bit, sa[WIDTH-1:1]};

    // NOTE: every register below is assigned with <= so all flops update
    // from the values present before the edge; blocking '=' here would let
    // later statements see already-updated state and break the shift chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            sa     <= '0;
            sb     <= '0;
            cnt    <= '0;
            borrow <= 1'b0;
            diff   <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
`ifdef RESTADOR_ZERO_FLAG_EN
            zero   <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                // DONE behaves like IDLE for acceptance; its done pulse was
                // raised on entry and drops on this edge either way.
                IDLE, DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    if (start) begin
                        sa     <= a;
                        sb     <= b;
                        borrow <= 1'b0;
                        cnt    <= '0;
                        state  <= RUN;
                        busy   <= 1'b1;
                    end
                end

                RUN: begin
                    sa     <= {d_bit, sa[WIDTH-1:1]};
                    sb     <= {1'b0, sb[WIDTH-1:1]};
                    borrow <= borrow_nxt;
                    cnt    <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        diff  <= diff_nxt;
`ifdef RESTADOR_ZERO_FLAG_EN
                        // a == b exactly when the full-width difference is 0.
                        zero  <= (diff_nxt == '0);
`endif
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_restador_serie.sv
// ---------------------------------------------------------------------------
// tb_restador_serie -- self-checking bench for restador_serie (WIDTH=4).
//
// A transaction-level model predicts busy/done/diff(/zero) from a countdown
// of remaining bit-cycles and the arithmetic result (a-b) mod 2^(WIDTH+1).
// A compare process checks the DUT against it on every falling edge; the
// directed sequences additionally pin literal values.
// ---------------------------------------------------------------------------
module tb_restador_serie;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic [W:0]   diff;
    logic         busy;
    logic         done;
`ifdef RESTADOR_ZERO_FLAG_EN
    logic         zero;
`endif

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;

    restador_serie #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .diff  (diff),
        .busy  (busy),
        .done  (done)
`ifdef RESTADOR_ZERO_FLAG_EN
        ,
        .zero  (zero)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    int         m_left = 0;     // bit-cycles still to go; >0 means busy
    bit         m_done = 1'b0;
    logic [W:0] m_diff = '0;
    bit         m_zero = 1'b0;
    logic [W:0] m_pend = '0;
    bit         m_pend_zero = 1'b0;

    always @(posedge clk) begin
        if (rst) begin
            m_left = 0;
            m_done = 1'b0;
            m_diff = '0;
            m_zero = 1'b0;
        end else if (m_left > 0) begin
            m_left = m_left - 1;
            m_done = (m_left == 0);
            if (m_done) begin
                m_diff = m_pend;
                m_zero = m_pend_zero;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                m_left      = W;
                m_pend      = (W+1)'(int'(a) - int'(b));
                m_pend_zero = (a == b);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_busy", 32'(busy), 32'(m_left > 0));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_diff", 32'(diff), 32'(m_diff));
`ifdef RESTADOR_ZERO_FLAG_EN
            check("cyc_zero", 32'(zero), 32'(m_zero));
`endif
        end
    end

    // ---------------- directed helpers ----------------
    // Wait (bounded) for done, counting busy cycles on the way.
    task automatic wait_done(input string name, output int busy_cycles);
        int n;
        busy_cycles = 0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            if (busy === 1'b1) busy_cycles++;
            @(negedge clk);
            n++;
        end
        if (done !== 1'b1) begin
            total++;
            bad++;
            $display("FAIL %s_timeout: done never rose within 40 cycles", name);
        end
    endtask

    task automatic op(input string name, input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                      input logic [W:0] exp, input int expz);
        int bc;
        @(negedge clk);
        a = ta;
        b = tb_v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_done(name, bc);
        check({name, "_busy_cycles"}, 32'(bc), 32'(W));
        check({name, "_diff"}, 32'(diff), 32'(exp));
`ifdef RESTADOR_ZERO_FLAG_EN
        check({name, "_zero"}, 32'(zero), 32'(expz));
`else
        if (expz < 0) $display("note: negative zero expectation ignored");
`endif
        @(negedge clk);
        check({name, "_done_drop"}, 32'(done), 32'd0);
        check({name, "_busy_idle"}, 32'(busy), 32'd0);
        check({name, "_diff_hold"}, 32'(diff), 32'(exp));
    endtask

    initial begin
        int bc;

        // Reset
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        check("rst_diff", 32'(diff), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);

        // Test-plan vectors with hand-computed results
        op("v0101_0011", 4'b0101, 4'b0011, 5'b00010, 0);
        op("v0010_0011", 4'b0010, 4'b0011, 5'b11111, 0);
        op("v0000_1111", 4'b0000, 4'b1111, 5'b10001, 0);
        op("v1111_0000", 4'b1111, 4'b0000, 5'b01111, 0);
        op("v1100_1010", 4'b1100, 4'b1010, 5'b00010, 0);
        op("v1001_1001", 4'b1001, 4'b1001, 5'b00000, 1);

        // Start held high: RUN ignores it, DONE accepts it
        @(negedge clk);
        a = 4'b1000;
        b = 4'b0001;
        start = 1'b1;
        for (int i = 0; i < W; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
        end
        @(negedge clk);
        check("held_done1", 32'(done), 32'd1);
        check("held_diff1", 32'(diff), 32'(5'b00111));
        a = 4'b0110;
        b = 4'b0011;
        @(negedge clk);
        start = 1'b0;
        check("held_busy2", 32'(busy), 32'd1);
        wait_done("held2", bc);
        check("held2_busy_cycles", 32'(bc), 32'(W));
        check("held_diff2", 32'(diff), 32'(5'b00011));

        // Reset during RUN aborts the operation
        @(negedge clk);
        a = 4'b0111;
        b = 4'b0010;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_diff", 32'(diff), 32'd0);
        for (int i = 0; i < W + 2; i++) begin
            @(negedge clk);
            check("abort_no_done", 32'(done), 32'd0);
        end
        op("after_abort", 4'b0111, 4'b0010, 5'b00101, 0);

        // rst and start together: reset wins
        @(negedge clk);
        a = 4'b0011;
        b = 4'b0001;
        start = 1'b1;
        rst = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        check("rst_start_busy", 32'(busy), 32'd0);
        check("rst_start_diff", 32'(diff), 32'd0);

        // Randomized traffic, checked cycle by cycle against the model
        for (int i = 0; i < 600; i++) begin
            @(negedge clk);
            a = W'($urandom);
            b = W'($urandom);
            start = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 60) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        rst = 1'b0;
        repeat (W + 3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/restador_serie.md
Name: restador_serie

Overview:
- Bit-serial unsigned subtractor; the inverse-direction counterpart of the team's 4-bit combinational adder.
- Accepts two WIDTH-bit operands on a start pulse and processes one bit per clock, LSB first, with a ripple borrow register.
- Returns a (WIDTH+1)-bit two's-complement difference a-b, framed by a busy/done handshake.
- Used where area matters more than latency, and as a sequential companion for checking the adder (sum - b == a).

Parameters:
WIDTH, 4, operand width in bits; must be >= 2.

Ports:
clk  input  1  system clock; all state changes on its rising edge.
rst  input  1  reset, synchronous, active-high; has priority over every other input.
start  input  1  request pulse; sampled only when busy=0.
a  input  WIDTH  minuend, unsigned; sampled on the accepting edge only.
b  input  WIDTH  subtrahend, unsigned; sampled on the accepting edge only.
diff  output  WIDTH+1  a-b in two's complement; bit WIDTH is the final borrow/sign.
busy  output  1  high while a subtraction is in progress.
done  output  1  one-cycle pulse marking a new valid diff.

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, diff=0, busy=0, done=0, bit counter=0, borrow=0, shift registers=0.
- FSM has three states: IDLE, RUN, DONE.
- busy=1 only in RUN. done=1 only in DONE.
- Accept: start=1 while busy=0 (IDLE or DONE) at an edge. Effects:
  - a and b are copied into shift registers.
  - borrow<=0, counter<=0, state<=RUN.
- RUN, each edge:
  - d_i = a_i XOR b_i XOR borrow.
  - borrow <= (~a_i & b_i) | (~(a_i ^ b_i) & borrow).
  - d_i is shifted into the result register; operand registers shift right; counter increments.
  - On the edge that processes bit WIDTH-1, state<=DONE.
  - On that same edge, diff<={final borrow, result bits}.
- Latency: done is high in the cycle beginning WIDTH edges after the accepting edge (4 cycles at WIDTH=4).
- Throughput: one result per WIDTH+1 cycles when start is held high.
- DONE lasts exactly one cycle, then goes to IDLE. A start sampled in DONE is accepted normally: it goes straight to RUN, and done still pulses for the previous result.
- diff is updated only on the transition into DONE. It holds its last value through IDLE and RUN, and until the next completion.
- start while busy=1 is ignored; no queuing; a and b are don't-care outside the accepting edge.
- Arithmetic rule: diff == (a - b) mod 2^(WIDTH+1). For unsigned inputs, diff[WIDTH]=1 iff a<b.
- Full range at WIDTH=4 is -15..+15; it always fits, so there is no overflow case.
- Reset mid-RUN aborts the operation: no done pulse, diff cleared to 0.
- rst=1 together with start=1: reset wins and the start is lost.

Optional Feature:
- Macro: RESTADOR_ZERO_FLAG_EN.
- Defined: adds output port zero (1 bit, reset 0). zero is registered together with diff on entry to DONE, equals 1 iff a==b, and holds like diff.
- Not defined: port zero and its logic are absent; all other behaviour is identical.

Test Plan:
- Reset, then a=4'b0101, b=4'b0011, start pulse:
  - busy=1 for 4 cycles, then done=1 for 1 cycle.
  - diff=5'b00010; busy back to 0.
- a=4'b0010, b=4'b0011 -> diff=5'b11111 (-1).
- a=4'b0000, b=4'b1111 -> diff=5'b10001 (-15).
- a=4'b1111, b=4'b0000 -> diff=5'b01111.
- a=4'b1100, b=4'b1010 -> diff=5'b00010. With RESTADOR_ZERO_FLAG_EN, zero=0.
- a=b=4'b1001 -> zero=1.
- Start a=4'b1000, b=4'b0001; hold start=1 with new operands during RUN -> ignored:
  - First result diff=5'b00111.
  - The start still high in the DONE cycle launches the second operation; its done follows 4 cycles later.
- Start a=4'b0111, b=4'b0010; assert rst on the 2nd RUN cycle:
  - No done pulse; diff=0, busy=0 next cycle.
  - A new start after rst releases completes normally with the correct result.
